// File: rtl/ctrl_seq.sv
// ctrl_seq: registered, multi-cycle control sequencer for the 16-bit CPU.
//
// Accepts instruction words over a valid/ready handshake and decodes them
// into one execute-stage register. Jumps cost one fetch bubble. Input and
// output instructions become blocking handshakes on one of NUM_IO_CH I/O
// channels, each abandoned after IO_TIMEOUT wait cycles (0 = never).
//
// Handshake semantics (all interfaces): a transfer happens on a rising clk
// edge where both valid and ready are high. Neither side may make valid
// depend on ready. This block's ready/valid outputs (instr_ready, in_ready,
// out_valid) are decoded from registers only, never from the peer's inputs.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             abort current instruction and pending issue
//   err_clr           clear the sticky io_err flag
//   instr/_valid/_ready  instruction handshake from fetch
//   ex_valid          one-cycle strobe: execute fields below are valid
//   alu_opcode, sel_a, sel_b, wr_back, sel_wr, imm  execute fields (held)
//   jump, jump_link, input_en  one-cycle strobes qualified by ex_valid
//   in_ready/in_valid per-channel input handshake
//   out_valid/out_ready output handshake; io_ch, out_reg_sel describe it
//   io_err            sticky error (bad channel or timeout)
//   dbg_state         current FSM state for observation
module ctrl_seq #(
  parameter int NUM_IO_CH  = 2,
  parameter int IO_TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 err_clr,
  input  logic [15:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic                 ex_valid,
  output logic [3:0]           alu_opcode,
  output logic [2:0]           sel_a,
  output logic [2:0]           sel_b,
  output logic                 wr_back,
  output logic [2:0]           sel_wr,
  output logic [7:0]           imm,
  output logic                 jump,
  output logic                 jump_link,
  output logic                 input_en,
  output logic [NUM_IO_CH-1:0] in_ready,
  input  logic [NUM_IO_CH-1:0] in_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           io_ch,
  output logic [2:0]           out_reg_sel,
  output logic                 io_err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_BUBBLE   = 2'd1,
    S_WAIT_IN  = 2'd2,
    S_WAIT_OUT = 2'd3
  } state_t;

  localparam logic [NUM_IO_CH-1:0] CH_ONE = NUM_IO_CH'(1);
  localparam logic [15:0]          TMO    = 16'(IO_TIMEOUT);
  localparam logic                 TMO_EN = (IO_TIMEOUT != 0);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [2:0]  pend_reg;   // rA of the I/O instruction being waited on

  // Field decode of the presented word.
  logic [2:0]  cls, ra, rb, rd, ch;
  logic [3:0]  fn;
  logic        ch_bad, accept, hs_in, tmo;
  logic [15:0] wait_next;

  always_comb begin
    cls       = instr[15:13];
    ra        = instr[12:10];
    rb        = instr[9:7];
    rd        = instr[6:4];
    fn        = instr[3:0];
    ch        = instr[9:7];
    ch_bad    = ({1'b0, ch} >= 4'(NUM_IO_CH));
    // A flush cycle never accepts, even though instr_ready may read high.
    accept    = instr_valid && (state == S_RUN) && !flush;
    // in_ready is one-hot on the waited channel, so this picks in_valid[ch].
    hs_in     = |(in_valid & in_ready);
    wait_next = wait_cnt + 16'd1;
    // True on the last permitted waiting cycle; a handshake still wins it.
    tmo       = TMO_EN && (wait_next == TMO);
  end

  assign instr_ready = (state == S_RUN);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      pend_reg    <= '0;
      ex_valid    <= 1'b0;
      alu_opcode  <= '0;
      sel_a       <= '0;
      sel_b       <= '0;
      wr_back     <= 1'b0;
      sel_wr      <= '0;
      imm         <= '0;
      jump        <= 1'b0;
      jump_link   <= 1'b0;
      input_en    <= 1'b0;
      in_ready    <= '0;
      out_valid   <= 1'b0;
      io_ch       <= '0;
      out_reg_sel <= '0;
      io_err      <= 1'b0;
    end else begin
      // Strobes last one cycle; the other execute fields hold.
      ex_valid  <= 1'b0;
      jump      <= 1'b0;
      jump_link <= 1'b0;
      input_en  <= 1'b0;
      // Any set below overrides this clear.
      if (err_clr) io_err <= 1'b0;

      if (flush) begin
        state     <= S_RUN;
        in_ready  <= '0;
        out_valid <= 1'b0;
        wait_cnt  <= '0;
      end else begin
        unique case (state)
          S_RUN: begin
            if (accept) begin
              if (!cls[2]) begin
                ex_valid <= 1'b1;
                imm      <= {1'b0, instr[6:0]};
                if (!cls[1]) begin
                  alu_opcode <= fn;
                  sel_a      <= ra;
                  sel_b      <= rb;
                  wr_back    <= 1'b1;
                  sel_wr     <= rd;
                end else if (!cls[0]) begin
                  jump       <= 1'b1;
                  alu_opcode <= 4'b0010;
                  wr_back    <= 1'b0;
                  state      <= S_BUBBLE;
                end else begin
                  jump_link  <= 1'b1;
                  sel_a      <= ra;
                  wr_back    <= 1'b0;
                  state      <= S_BUBBLE;
                end
              end else if (ch_bad) begin
                io_err <= 1'b1;
              end else begin
                io_ch    <= ch;
                pend_reg <= ra;
                wait_cnt <= '0;
                if (cls[0]) begin
                  out_valid   <= 1'b1;
                  out_reg_sel <= ra;
                  state       <= S_WAIT_OUT;
                end else begin
                  in_ready <= CH_ONE << ch;
                  state    <= S_WAIT_IN;
                end
              end
            end
          end
          S_BUBBLE: state <= S_RUN;
          S_WAIT_IN: begin
            if (hs_in) begin
              ex_valid <= 1'b1;
              input_en <= 1'b1;
              wr_back  <= 1'b1;
              sel_wr   <= pend_reg;
              in_ready <= '0;
              state    <= S_RUN;
            end else if (tmo) begin
              io_err   <= 1'b1;
              in_ready <= '0;
              state    <= S_RUN;
            end else begin
              wait_cnt <= wait_next;
            end
          end
          S_WAIT_OUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= S_RUN;
            end else if (tmo) begin
              io_err    <= 1'b1;
              out_valid <= 1'b0;
              state     <= S_RUN;
            end else begin
              wait_cnt <= wait_next;
            end
          end
          default: state <= S_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed scenario tasks plus a randomized instruction stream
// checked against a transaction-level model of the issue stream.
module tb_ctrl_seq;
  localparam int NCH = 2;
  localparam int T   = 4;

  logic            clk, rst, flush, err_clr;
  logic [15:0]     instr;
  logic            instr_valid, instr_ready;
  logic            ex_valid;
  logic [3:0]      alu_opcode;
  logic [2:0]      sel_a, sel_b, sel_wr;
  logic            wr_back;
  logic [7:0]      imm;
  logic            jump, jump_link, input_en;
  logic [NCH-1:0]  in_ready, in_valid;
  logic            out_valid, out_ready;
  logic [2:0]      io_ch, out_reg_sel;
  logic            io_err;
  logic [1:0]      dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  // Scoreboard of expected issue packets:
  // {jump, jump_link, input_en, wr_back, alu_opcode, sel_a, sel_b, sel_wr, imm}
  logic [24:0] exp_q[$];
  bit          sb_en = 1'b0;

  ctrl_seq #(.NUM_IO_CH(NCH), .IO_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .ex_valid(ex_valid), .alu_opcode(alu_opcode), .sel_a(sel_a),
    .sel_b(sel_b), .wr_back(wr_back), .sel_wr(sel_wr), .imm(imm),
    .jump(jump), .jump_link(jump_link), .input_en(input_en),
    .in_ready(in_ready), .in_valid(in_valid), .out_valid(out_valid),
    .out_ready(out_ready), .io_ch(io_ch), .out_reg_sel(out_reg_sel),
    .io_err(io_err), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Driver helpers: inputs change and outputs are sampled at negedge.
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [36:0] rst_word();
    return {instr_ready, ex_valid, alu_opcode, sel_a, sel_b, wr_back, sel_wr,
            imm, jump, jump_link, input_en, in_ready, out_valid, io_ch,
            out_reg_sel, io_err};
  endfunction

  function automatic logic [24:0] issue_word();
    return {jump, jump_link, input_en, wr_back, alu_opcode, sel_a, sel_b,
            sel_wr, imm};
  endfunction

  // Scoreboard: every ex_valid cycle must match the next expected packet.
  always @(negedge clk) begin
    if (sb_en && ex_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_issue got %h exp none", issue_word());
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        if (issue_word() !== e) begin
          miscompares++;
          $display("FAIL sb_issue got %h exp %h", issue_word(), e);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    vectors++;
    if (rst_word() !== 37'h10_0000_0000) begin
      miscompares++;
      $display("FAIL reset_values got %h exp %h", rst_word(), 37'h10_0000_0000);
    end
    rst = 1'b0; tick();
    vectors++;
    if ({instr_ready, ex_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL post_reset_ready got %b exp 10", {instr_ready, ex_valid});
    end
  endtask

  task automatic test_alu();
    instr = 16'h0A53; instr_valid = 1'b1; tick();
    vectors++;
    if ({ex_valid, alu_opcode, sel_a, sel_b, wr_back, sel_wr} !==
        {1'b1, 4'd3, 3'd2, 3'd4, 1'b1, 3'd5}) begin
      miscompares++;
      $display("FAIL alu_first got %h exp %h",
               {ex_valid, alu_opcode, sel_a, sel_b, wr_back, sel_wr},
               {1'b1, 4'd3, 3'd2, 3'd4, 1'b1, 3'd5});
    end
    instr = 16'h0000; tick();
    vectors++;
    if ({ex_valid, alu_opcode, sel_a, sel_b, wr_back, sel_wr} !==
        {1'b1, 4'd0, 3'd0, 3'd0, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL alu_second got %h exp %h",
               {ex_valid, alu_opcode, sel_a, sel_b, wr_back, sel_wr},
               {1'b1, 4'd0, 3'd0, 3'd0, 1'b1, 3'd0});
    end
    instr_valid = 1'b0; tick();
    vectors++;
    if ({ex_valid, wr_back} !== 2'b01) begin
      miscompares++;
      $display("FAIL alu_idle_hold got %b exp 01", {ex_valid, wr_back});
    end
  endtask

  task automatic test_jump();
    instr = 16'h402A; instr_valid = 1'b1; tick();
    vectors++;
    if ({ex_valid, jump, imm, alu_opcode, wr_back, instr_ready} !==
        {1'b1, 1'b1, 8'h2A, 4'b0010, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL jump_issue got %h exp %h",
               {ex_valid, jump, imm, alu_opcode, wr_back, instr_ready},
               {1'b1, 1'b1, 8'h2A, 4'b0010, 1'b0, 1'b0});
    end
    // The jump-register word waits through the bubble.
    instr = 16'h6C00; tick();
    vectors++;
    if ({ex_valid, jump, instr_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL jump_bubble got %b exp 001", {ex_valid, jump, instr_ready});
    end
    tick();
    vectors++;
    if ({ex_valid, jump_link, sel_a, wr_back, instr_ready} !==
        {1'b1, 1'b1, 3'd3, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL jump_link_issue got %h exp %h",
               {ex_valid, jump_link, sel_a, wr_back, instr_ready},
               {1'b1, 1'b1, 3'd3, 1'b0, 1'b0});
    end
    instr_valid = 1'b0; tick();
    vectors++;
    if ({ex_valid, jump_link, instr_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL jump_link_end got %b exp 001", {ex_valid, jump_link, instr_ready});
    end
  endtask

  task automatic test_input();
    instr = 16'h8C80; instr_valid = 1'b1; tick();
    instr_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      vectors++;
      if ({in_ready, instr_ready, ex_valid} !== 4'b1000) begin
        miscompares++;
        $display("FAIL input_wait%0d got %b exp 1000", k, {in_ready, instr_ready, ex_valid});
      end
      if (k == 3) in_valid = 2'b10;
      else in_valid = 2'b01;  // other channel must be ignored
      tick();
    end
    in_valid = 2'b00;
    vectors++;
    if ({ex_valid, input_en, wr_back, sel_wr, in_ready, instr_ready} !==
        {1'b1, 1'b1, 1'b1, 3'd3, 2'b00, 1'b1}) begin
      miscompares++;
      $display("FAIL input_issue got %h exp %h",
               {ex_valid, input_en, wr_back, sel_wr, in_ready, instr_ready},
               {1'b1, 1'b1, 1'b1, 3'd3, 2'b00, 1'b1});
    end
  endtask

  task automatic test_bad_channel();
    instr = 16'hA280; instr_valid = 1'b1; tick();
    instr_valid = 1'b0;
    vectors++;
    if ({io_err, out_valid, instr_ready, ex_valid} !== 4'b1010) begin
      miscompares++;
      $display("FAIL bad_ch got %b exp 1010", {io_err, out_valid, instr_ready, ex_valid});
    end
    tick();
    vectors++;
    if ({io_err, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL bad_ch_sticky got %b exp 10", {io_err, out_valid});
    end
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    vectors++;
    if (io_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clr got %b exp 0", io_err);
    end
    // A set in the same cycle as err_clr wins.
    instr = 16'hA280; instr_valid = 1'b1; err_clr = 1'b1; tick();
    instr_valid = 1'b0; err_clr = 1'b0;
    vectors++;
    if (io_err !== 1'b1) begin
      miscompares++;
      $display("FAIL set_beats_clr got %b exp 1", io_err);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_timeout();
    instr = 16'hAC80; instr_valid = 1'b1; out_ready = 1'b0; tick();
    instr_valid = 1'b0;
    for (int k = 1; k <= T; k++) begin
      vectors++;
      if ({out_valid, io_ch, out_reg_sel, io_err} !== {1'b1, 3'd1, 3'd3, 1'b0}) begin
        miscompares++;
        $display("FAIL timeout_wait%0d got %h exp %h", k,
                 {out_valid, io_ch, out_reg_sel, io_err}, {1'b1, 3'd1, 3'd3, 1'b0});
      end
      tick();
    end
    vectors++;
    if ({out_valid, io_err, instr_ready, ex_valid} !== 4'b0110) begin
      miscompares++;
      $display("FAIL timeout_abort got %b exp 0110", {out_valid, io_err, instr_ready, ex_valid});
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    // Handshake on the last permitted cycle completes without error.
    instr = 16'hAC80; instr_valid = 1'b1; tick();
    instr_valid = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    vectors++;
    if ({out_valid, io_err, instr_ready, ex_valid} !== 4'b0010) begin
      miscompares++;
      $display("FAIL handshake_at_T got %b exp 0010", {out_valid, io_err, instr_ready, ex_valid});
    end
  endtask

  task automatic test_flush();
    instr = 16'h8C80; instr_valid = 1'b1; tick();
    instr_valid = 1'b0;
    // Flush beats a simultaneous input handshake.
    flush = 1'b1; in_valid = 2'b10; tick();
    flush = 1'b0; in_valid = 2'b00;
    vectors++;
    if ({in_ready, ex_valid, input_en, instr_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL flush_wait_in got %b exp 00001", {in_ready, ex_valid, input_en, instr_ready});
    end
    // No accept during a flush cycle.
    instr = 16'h0A53; instr_valid = 1'b1; flush = 1'b1; tick();
    flush = 1'b0;
    vectors++;
    if (ex_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_accept got %b exp 0", ex_valid);
    end
    tick();
    instr_valid = 1'b0;
    vectors++;
    if ({ex_valid, alu_opcode} !== {1'b1, 4'd3}) begin
      miscompares++;
      $display("FAIL after_flush_accept got %h exp %h", {ex_valid, alu_opcode}, {1'b1, 4'd3});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    instr = 16'hA280; instr_valid = 1'b1; tick();   // set io_err
    instr = 16'hAC80; tick();
    instr_valid = 1'b0;
    vectors++;
    if ({out_valid, io_err} !== 2'b11) begin
      miscompares++;
      $display("FAIL pre_reset_out got %b exp 11", {out_valid, io_err});
    end
    rst = 1'b1; tick();
    vectors++;
    if (rst_word() !== 37'h10_0000_0000) begin
      miscompares++;
      $display("FAIL reset_mid_out got %h exp %h", rst_word(), 37'h10_0000_0000);
    end
    rst = 1'b0; tick();
  endtask

  // Random stream against a transaction-level model: the model tracks the
  // last value of each execute field and the error flag, and predicts the
  // packet issued for each instruction from the class rules.
  task automatic test_random();
    logic [15:0]    w;
    logic [2:0]     ra, rb, rd, ch;
    logic [3:0]     fn;
    logic [NCH-1:0] oh;
    logic [3:0]     m_alu;
    logic [2:0]     m_sa, m_sb, m_sw;
    logic [7:0]     m_imm;
    logic           m_wb, m_err, bad, clr;
    int             d;
    rst = 1'b1; tick(); rst = 1'b0;
    m_alu = '0; m_sa = '0; m_sb = '0; m_sw = '0; m_imm = '0; m_wb = 1'b0; m_err = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;
    for (int n = 0; n < 120; n++) begin
      w  = 16'($urandom);
      ra = w[12:10]; rb = w[9:7]; rd = w[6:4]; fn = w[3:0]; ch = w[9:7];
      clr = ($urandom_range(0, 3) == 0);
      bad = w[15] && (int'(ch) >= NCH);
      vectors++;
      if ({instr_ready, io_err} !== {1'b1, m_err}) begin
        miscompares++;
        $display("FAIL rand_pre%0d got %b exp %b", n, {instr_ready, io_err}, {1'b1, m_err});
      end
      instr = w; instr_valid = 1'b1; err_clr = clr;
      if (!w[15]) begin
        m_imm = {1'b0, w[6:0]};
        if (!w[14]) begin
          m_alu = fn; m_sa = ra; m_sb = rb; m_wb = 1'b1; m_sw = rd;
          exp_q.push_back({3'b000, m_wb, m_alu, m_sa, m_sb, m_sw, m_imm});
        end else if (!w[13]) begin
          m_alu = 4'b0010; m_wb = 1'b0;
          exp_q.push_back({3'b100, m_wb, m_alu, m_sa, m_sb, m_sw, m_imm});
        end else begin
          m_sa = ra; m_wb = 1'b0;
          exp_q.push_back({3'b010, m_wb, m_alu, m_sa, m_sb, m_sw, m_imm});
        end
      end
      m_err = bad ? 1'b1 : (clr ? 1'b0 : m_err);
      tick();
      instr_valid = 1'b0; err_clr = 1'b0;
      if (!w[15] && w[14]) begin
        vectors++;
        if (instr_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_bubble%0d got %b exp 0", n, instr_ready);
        end
        tick();
      end else if (w[15] && !bad) begin
        oh = NCH'(1) << ch;
        d  = $urandom_range(0, 6);
        vectors++;
        if (!w[13] && (in_ready !== oh || out_valid !== 1'b0)) begin
          miscompares++;
          $display("FAIL rand_in_ready%0d got %b exp %b", n, in_ready, oh);
        end else if (w[13] && (out_valid !== 1'b1 || in_ready !== '0)) begin
          miscompares++;
          $display("FAIL rand_out_valid%0d got %b exp 1", n, out_valid);
        end
        for (int k = 1; k <= T; k++) begin
          if (k == d + 1) begin
            if (!w[13]) begin
              in_valid = NCH'($urandom) | oh;
              m_wb = 1'b1; m_sw = ra;
              exp_q.push_back({3'b001, m_wb, m_alu, m_sa, m_sb, m_sw, m_imm});
            end else begin
              out_ready = 1'b1;
            end
          end else begin
            in_valid = NCH'($urandom) & ~oh;
          end
          tick();
          if (k == d + 1) break;
        end
        in_valid = '0; out_ready = 1'b0;
        if (d + 1 > T) m_err = 1'b1;
      end
    end
    tick(); tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_missing_issues got %0d exp 0", exp_q.size());
    end
    sb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; err_clr = 1'b0; instr = '0; instr_valid = 1'b0;
    in_valid = '0; out_ready = 1'b0;
    test_reset();
    test_alu();
    test_jump();
    test_input();
    test_bad_channel();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
